multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 16-bit datapath: PC, instruction register, 4-entry register file and one shared ALU.
- One ALU serves both the PC+2 increment and instruction execution; this block selects its operands and function in each state.
- Sits between the instruction-memory handshake and the datapath mux/latch enables.
- Provides halt and fault status plus cycle and retired-instruction counters.

Parameters:
- FETCH_TIMEOUT, default 15: maximum cycles FETCH waits for mem_ready before FAULT (range 1..255).
- CNT_W, default 16: width of the performance counters.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; leaves IDLE when high.
- ir  in  16  current instruction-register contents.
- mem_ready  in  1  instruction memory has valid data this cycle.
- mem_req  out  1  fetch request to instruction memory.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC from ALU result.
- ab_write  out  1  latch register-file RD1/RD2 into A/B.
- alu_out_write  out  1  latch ALU result into ALUOut.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  00=B, 01=constant 2, 10=sign-extended ir[7:0].
- alu_control  out  4  ALU function {ainvert, binvert, op[1:0]}.
- reg_dst  out  1  1=write register ir[7:6], 0=ir[9:8].
- reg_write  out  1  register-file write enable.
- halted  out  1  in HALT.
- fault  out  1  in FAULT.
- cycle_count  out  CNT_W  active cycles.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, timeout counter=0, both counters=0.
  - Every output 0, including while reset is held.
  - Reset mid-instruction abandons it; no reg_write or pc_write is issued.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, FAULT.
- IDLE: outputs 0; go to FETCH when start=1.
- FETCH:
  - mem_req=1, alu_src_a=0, alu_src_b=01, alu_control=0010.
  - ir_write=pc_write=mem_ready (Mealy).
  - mem_ready=1: go to DECODE, clear the timeout counter.
  - mem_ready=0: increment the timeout counter. When it reaches FETCH_TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 arriving in the same cycle the count would expire wins: go to DECODE.
- DECODE:
  - ab_write=1.
  - ir==16'hFFFF: go to HALT.
  - Opcode 1000..1110, or 1111 with ir!=FFFF: treated as NOP; increment instr_count, go to FETCH.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - alu_src_a=1, alu_out_write=1; go to WRITEBACK.
  - Opcode map (ir[15:12] -> alu_control):
    - 0000 -> 0010 add
    - 0001 -> 0110 sub
    - 0010 -> 0000 and
    - 0011 -> 0001 or
    - 0100 -> 1100 nor
    - 0101 -> 1101 nand
    - 0110 -> 0111 slt
    - 0111 -> 0010 addi
  - alu_src_b=10 for 0111, 00 otherwise.
- WRITEBACK:
  - reg_write=1; reg_dst=0 for 0111, 1 otherwise.
  - Increment instr_count, go to FETCH.
  - Register 0 write suppression belongs to the register file, not this block.
- HALT and FAULT are terminal until reset; halted and fault are 1 respectively, all other outputs 0.
- ir is sampled live. The datapath holds IR stable outside ir_write, so the controller does not copy the opcode.
- cycle_count increments in FETCH, DECODE, EXECUTE and WRITEBACK only.
- Both counters wrap modulo 2^CNT_W with no saturation.
- start is ignored outside IDLE.
- Latency: 4 cycles per ALU instruction with zero-wait memory; NOP and halt take 2.

Decomposition:
- Shared package multicycle_pkg:
  - state encoding (3-bit localparams);
  - opcode constants OP_ADD..OP_ADDI and HALT_WORD=16'hFFFF;
  - ALU control codes ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100, ALU_NAND=1101;
  - alu_src_b codes.
- One sub-module, multicycle_decode: combinational opcode -> {alu_control, alu_src_b_imm, reg_dst, valid}.

Test Plan:
- Reset held 3 cycles, then start=1, mem_ready tied 1, single instruction 0111_00_01_00001111 followed by FFFF:
  - FETCH/DECODE/EXECUTE/WRITEBACK each last 1 cycle;
  - in EXECUTE, alu_src_b=10 and alu_control=0010;
  - in WRITEBACK, reg_write=1 and reg_dst=0;
  - HALT follows; instr_count=1, cycle_count=6.
- Nine-instruction program (two addi, and, sub, or, add, nor, two slt) then FFFF, zero-wait memory -> instr_count=9, cycle_count=38, halted=1, fault=0.
- mem_ready delayed 3 cycles on the first fetch -> mem_req high for 4 cycles; ir_write and pc_write pulse only in the 4th; cycle_count includes the wait cycles.
- mem_ready held 0 -> FAULT after FETCH_TIMEOUT=15 cycles; fault=1, mem_req=0; start toggling has no effect until reset.
- Opcode 1010 -> DECODE goes directly to FETCH; no reg_write; instr_count increments.
- Reset asserted asynchronously during EXECUTE of a sub -> all outputs 0 immediately, no WRITEBACK; counters are 0 after release.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// opcodes, ALU function codes, ALU operand-B selects and the control bundle.
package multicycle_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_EXECUTE   = ST_EXECUTE,
        S_WRITEBACK = ST_WRITEBACK,
        S_HALT      = ST_HALT,
        S_FAULT     = ST_FAULT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    // ALU function encoding {ainvert, binvert, op[1:0]}
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_TWO = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // Registered (Moore) control outputs; the fetch strobes are Mealy and live outside.
    typedef struct packed {
        logic       mem_req;
        logic       ab_write;
        logic       alu_out_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       reg_dst;
        logic       reg_write;
        logic       halted;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-fetch link between the controller and instruction memory / IR.
// Handshake: mem_req is held high for every FETCH cycle; memory raises
// mem_ready in the cycle its data is valid. A transfer happens on the rising
// edge where mem_req && mem_ready, and in that same cycle ir_write loads the
// instruction register. ir is the IR contents, stable except after ir_write.
interface multicycle_controller_if;
    logic        mem_req;
    logic        mem_ready;
    logic        ir_write;
    logic [15:0] ir;

    modport master (output mem_req, output ir_write, input mem_ready, input ir);
    modport slave  (input mem_req, input ir_write, output mem_ready, output ir);
endinterface

// File: rtl/multicycle_decode.sv
// Combinational opcode decoder: ALU function, immediate operand select,
// destination-field select and whether the opcode is an ALU instruction.
module multicycle_decode
    import multicycle_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [3:0] alu_control_o,
    output logic       alu_src_b_imm_o,
    output logic       reg_dst_o,
    output logic       valid_o
);

    // Map opcode to ALU controls; opcodes with the top bit set are not ALU ops.
    always_comb begin
        alu_control_o   = ALU_ADD;
        alu_src_b_imm_o = 1'b0;
        reg_dst_o       = 1'b1;
        valid_o         = 1'b1;
        case (opcode_i)
            OP_ADD:  alu_control_o = ALU_ADD;
            OP_SUB:  alu_control_o = ALU_SUB;
            OP_AND:  alu_control_o = ALU_AND;
            OP_OR:   alu_control_o = ALU_OR;
            OP_NOR:  alu_control_o = ALU_NOR;
            OP_NAND: alu_control_o = ALU_NAND;
            OP_SLT:  alu_control_o = ALU_SLT;
            OP_ADDI: begin
                alu_control_o   = ALU_ADD;
                alu_src_b_imm_o = 1'b1;
                reg_dst_o       = 1'b0;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: steps FETCH/DECODE/EXECUTE/WRITEBACK, drives the
// shared-ALU operand selects and datapath enables, and keeps status counters.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    multicycle_controller_if.master imem,
    output logic                   pc_write,
    output logic                   ab_write,
    output logic                   alu_out_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [3:0]             alu_control,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   halted,
    output logic                   fault,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       instr_count,
    output state_t                 dbg_state
);

    localparam logic [7:0] TMO_LIMIT = 8'(FETCH_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cycle_q, instr_q;
    logic             retire;
    logic             active;
    logic             fetch_hit;

    logic [3:0] dec_alu_control;
    logic       dec_src_b_imm;
    logic       dec_reg_dst;
    logic       dec_valid;

    multicycle_decode u_decode (
        .opcode_i        (imem.ir[15:12]),
        .alu_control_o   (dec_alu_control),
        .alu_src_b_imm_o (dec_src_b_imm),
        .reg_dst_o       (dec_reg_dst),
        .valid_o         (dec_valid)
    );

    assign fetch_hit = (state_q == S_FETCH) && imem.mem_ready;
    assign active    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

    // Next state, fetch timeout and retirement; IR is read live since the datapath holds it.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem.mem_ready) begin
                    state_d = S_DECODE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_LIMIT) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (imem.ir == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (!dec_valid) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Controls for the state being entered, so they can be registered at the same edge.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req     = 1'b1;
                ctrl_d.alu_src_b   = SRCB_TWO;
                ctrl_d.alu_control = ALU_ADD;
            end
            S_DECODE: ctrl_d.ab_write = 1'b1;
            S_EXECUTE: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_out_write = 1'b1;
                ctrl_d.alu_src_b     = dec_src_b_imm ? SRCB_IMM : SRCB_B;
                ctrl_d.alu_control   = dec_alu_control;
            end
            S_WRITEBACK: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = dec_reg_dst;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            S_FAULT: ctrl_d.fault  = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // State, registered controls and counters; reset abandons any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            ctrl_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= ctrl_d;
            if (active) cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign imem.mem_req  = ctrl_q.mem_req;
    assign imem.ir_write = fetch_hit;
    assign pc_write      = fetch_hit;
    assign ab_write      = ctrl_q.ab_write;
    assign alu_out_write = ctrl_q.alu_out_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_control   = ctrl_q.alu_control;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign halted        = ctrl_q.halted;
    assign fault         = ctrl_q.fault;
    assign cycle_count   = cycle_q;
    assign instr_count   = instr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed programs plus random programs
// with random memory wait states, checked against per-instruction costs.
module tb_multicycle_controller;
    import multicycle_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        pc_write, ab_write, alu_out_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        reg_dst, reg_write, halted, fault;
    logic [15:0] cycle_count, instr_count;
    state_t      dbg_state;

    int checks;
    int errors;

    logic [15:0] prog[$];
    int          waits[$];

    multicycle_controller_if imem_if ();

    multicycle_controller #(.FETCH_TIMEOUT(15), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .imem          (imem_if.master),
        .pc_write      (pc_write),
        .ab_write      (ab_write),
        .alu_out_write (alu_out_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .halted        (halted),
        .fault         (fault),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU function table for opcodes 0..7
    function automatic logic [3:0] exp_alu(input logic [3:0] op);
        case (op)
            4'd0: return 4'b0010;
            4'd1: return 4'b0110;
            4'd2: return 4'b0000;
            4'd3: return 4'b0001;
            4'd4: return 4'b1100;
            4'd5: return 4'b1101;
            4'd6: return 4'b0111;
            4'd7: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk(tag, {imem_if.mem_req, imem_if.ir_write, pc_write, ab_write, alu_out_write,
                  alu_src_a, alu_src_b, alu_control, reg_dst, reg_write, halted, fault,
                  cycle_count, instr_count}, 64'd0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        imem_if.mem_ready = 1'b0;
        #1 check_all_zero("reset_assert");
        repeat (n) begin
            @(negedge clock);
            #1 check_all_zero("reset_held");
        end
        @(negedge clock);
        reset = 1'b0;
        #1 check_all_zero("reset_release");
    endtask

    task automatic gen_random_prog(input int n);
        logic [15:0] w;
        prog.delete();
        waits.delete();
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            if (w == HALT_WORD) w = 16'hF000;
            prog.push_back(w);
            waits.push_back(int'($urandom_range(0, 3)));
        end
        prog.push_back(HALT_WORD);
        waits.push_back(int'($urandom_range(0, 3)));
    endtask

    // Runs prog/waits from IDLE to HALT with a memory model and checks every instruction.
    task automatic run_prog(input string name);
        int pc, wait_left, fetch_len, budget;
        int n_regw, n_ab, n_irw, n_pcw;
        int exp_cycles, exp_instr, exp_regw;
        bit load_pending;
        logic [3:0] op;
        logic [3:0] exp_ctrl_q[$];
        logic [1:0] exp_srcb_q[$];
        logic       exp_dst_q[$];
        int         exp_flen_q[$];

        exp_cycles = 0; exp_instr = 0; exp_regw = 0;
        foreach (prog[i]) begin
            op = prog[i][15:12];
            exp_flen_q.push_back(waits[i] + 1);
            if (prog[i] == HALT_WORD) begin
                exp_cycles += waits[i] + 2;
            end else if (op >= 4'd8) begin
                exp_cycles += waits[i] + 2;
                exp_instr++;
            end else begin
                exp_cycles += waits[i] + 4;
                exp_instr++;
                exp_regw++;
                exp_ctrl_q.push_back(exp_alu(op));
                exp_srcb_q.push_back((op == 4'd7) ? 2'b10 : 2'b00);
                exp_dst_q.push_back(op != 4'd7);
            end
        end

        pc = 0; wait_left = waits[0]; fetch_len = 0; budget = 0; load_pending = 0;
        n_regw = 0; n_ab = 0; n_irw = 0; n_pcw = 0;
        while (!halted && budget < 3000) begin
            @(negedge clock);
            if (load_pending) begin
                if (pc < prog.size()) imem_if.ir = prog[pc];
                pc++;
                wait_left = (pc < prog.size()) ? waits[pc] : 0;
                load_pending = 0;
            end
            start = (budget == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            imem_if.mem_ready = (wait_left == 0);
            #1;
            if (!imem_if.mem_ready) chk({name, "_ir_write_no_ready"}, imem_if.ir_write, 1'b0);
            if (imem_if.mem_req) begin
                fetch_len++;
                if (!imem_if.mem_ready) wait_left--;
            end
            if (imem_if.ir_write) begin
                n_irw++;
                if (exp_flen_q.size() > 0) chk({name, "_fetch_len"}, 64'(fetch_len), 64'(exp_flen_q.pop_front()));
                else chk({name, "_extra_fetch"}, imem_if.ir_write, 1'b0);
                fetch_len = 0;
                load_pending = 1;
            end
            if (pc_write) n_pcw++;
            if (ab_write) n_ab++;
            if (alu_out_write) begin
                if (exp_ctrl_q.size() > 0) begin
                    chk({name, "_alu_control"}, alu_control, exp_ctrl_q.pop_front());
                    chk({name, "_alu_src_b"}, alu_src_b, exp_srcb_q.pop_front());
                    chk({name, "_alu_src_a"}, alu_src_a, 1'b1);
                end else begin
                    chk({name, "_extra_execute"}, alu_out_write, 1'b0);
                end
            end
            if (reg_write) begin
                n_regw++;
                if (exp_dst_q.size() > 0) chk({name, "_reg_dst"}, reg_dst, exp_dst_q.pop_front());
                else chk({name, "_extra_reg_write"}, reg_write, 1'b0);
            end
            budget++;
        end

        chk({name, "_halted"}, halted, 1'b1);
        chk({name, "_fault"}, fault, 1'b0);
        chk({name, "_cycle_count"}, cycle_count, 64'(exp_cycles));
        chk({name, "_instr_count"}, instr_count, 64'(exp_instr));
        chk({name, "_reg_writes"}, 64'(n_regw), 64'(exp_regw));
        chk({name, "_ab_writes"}, 64'(n_ab), 64'(prog.size()));
        chk({name, "_ir_writes"}, 64'(n_irw), 64'(prog.size()));
        chk({name, "_pc_writes"}, 64'(n_pcw), 64'(prog.size()));

        // HALT is terminal regardless of start
        repeat (2) begin
            @(negedge clock);
            start = ~start;
            imem_if.mem_ready = 1'b1;
            #1;
            chk({name, "_halt_sticky"}, {halted, imem_if.mem_req, reg_write}, 3'b100);
            chk({name, "_halt_cycles"}, cycle_count, 64'(exp_cycles));
        end
        start = 1'b0;
    endtask

    initial begin
        int  n_req;
        int  n_rw;
        bit  ld;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        imem_if.mem_ready = 1'b0;
        imem_if.ir = 16'h0000;

        // Single addi then halt, zero-wait memory
        apply_reset(3);
        prog = '{16'b0111_00_01_00001111, HALT_WORD};
        waits = '{0, 0};
        run_prog("addi");
        chk("addi_cycles6", cycle_count, 16'd6);
        chk("addi_instr1", instr_count, 16'd1);

        // Nine-instruction program
        apply_reset(2);
        prog = '{16'h7105, 16'h72F3, 16'h2E40, 16'h1B21, 16'h3A05,
                 16'h0D77, 16'h4C12, 16'h6944, 16'h6A80, HALT_WORD};
        waits = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_prog("nine");
        chk("nine_cycles38", cycle_count, 16'd38);
        chk("nine_instr9", instr_count, 16'd9);

        // First fetch delayed by three cycles
        apply_reset(2);
        prog = '{16'h7142, HALT_WORD};
        waits = '{3, 0};
        run_prog("delay");
        chk("delay_cycles9", cycle_count, 16'd9);

        // Opcode 1010 behaves as NOP
        apply_reset(2);
        prog = '{16'hA5C3, HALT_WORD};
        waits = '{0, 0};
        run_prog("nop");
        chk("nop_cycles4", cycle_count, 16'd4);
        chk("nop_instr1", instr_count, 16'd1);

        // Random programs with random wait states
        for (int r = 0; r < 5; r++) begin
            apply_reset(1);
            gen_random_prog(int'($urandom_range(4, 14)));
            run_prog("rand");
        end

        // mem_ready never arrives: FAULT after the timeout
        apply_reset(2);
        n_req = 0;
        for (int c = 0; c < 100 && !fault; c++) begin
            @(negedge clock);
            start = (c == 0);
            imem_if.mem_ready = 1'b0;
            #1;
            if (imem_if.mem_req) n_req++;
        end
        chk("tmo_fault", fault, 1'b1);
        chk("tmo_req_cycles", 64'(n_req), 64'd15);
        chk("tmo_mem_req", imem_if.mem_req, 1'b0);
        chk("tmo_cycles", cycle_count, 16'd15);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            start = ~start;
            imem_if.mem_ready = 1'b1;
            #1;
            chk("tmo_sticky", {fault, halted, imem_if.mem_req, imem_if.ir_write}, 4'b1000);
        end

        // Asynchronous reset in the EXECUTE cycle of a sub
        apply_reset(2);
        ld = 0;
        for (int c = 0; c < 50 && !alu_out_write; c++) begin
            @(negedge clock);
            if (ld) begin
                imem_if.ir = 16'h1A55;
                ld = 0;
            end
            start = (c == 0);
            imem_if.mem_ready = 1'b1;
            #1;
            if (imem_if.ir_write) ld = 1;
        end
        chk("rst_reached_execute", alu_out_write, 1'b1);
        chk("rst_execute_ctrl", alu_control, 4'b0110);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async_immediate");
        n_rw = 0;
        repeat (2) begin
            @(negedge clock);
            #1;
            if (reg_write) n_rw++;
            check_all_zero("rst_async_held");
        end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        #1 check_all_zero("rst_async_release");
        chk("rst_state_idle", dbg_state, S_IDLE);
        repeat (3) begin
            @(negedge clock);
            #1;
            if (reg_write) n_rw++;
        end
        chk("rst_no_reg_write", 64'(n_rw), 64'd0);
        chk("rst_counters", {cycle_count, instr_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
